gam_connection_memory: RTL and testbench
========================================

# gam_connection_memory

Parametrised per-class edge memory for the GAM learning layer. It stores, for each class, a symmetric node-adjacency matrix with a presence bit and an age counter per edge. It runs the connect/age update issued by the learning layer and the end-of-learning prune sweep as multi-cycle FSM operations behind a valid/ready command port. It also tracks per-node validity for the downstream recall logic.

## Interface
- CLASS_COUNT, 4, number of classes
- NODE_COUNT, 16, nodes per class (indices 0..NODE_COUNT-1)
- AGE_W, 6, age counter width
- AGE_MAX, 50, prune threshold; must satisfy 1 <= AGE_MAX <= 2^AGE_W-1
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0 = CONNECT, 1 = PRUNE
- cmd_class  in  $clog2(CLASS_COUNT)  target class
- cmd_node_a, cmd_node_b  in  $clog2(NODE_COUNT)  edge endpoints (ignored for PRUNE)
- done  out  1  one-cycle pulse on command completion
- err  out  1  one-cycle pulse when a command is rejected
- pruned_count  out  $clog2(NODE_COUNT*NODE_COUNT)+1  edges removed by the last PRUNE
- node_valid  out  CLASS_COUNT*NODE_COUNT  bit [c*NODE_COUNT+n] means node n of class c is valid
- q_class, q_a, q_b  in  as cmd fields  query address
- q_present  out  1  edge presence, registered
- q_age  out  AGE_W  edge age, registered

## Operation
- FSM states: IDLE, WRITE, AGE, PRUNE_EDGE, PRUNE_NODE.
- Accept: cmd_valid && cmd_ready samples all cmd_* fields into internal registers.
- Reject: a CONNECT with node_a == node_b, or any out-of-range class or node index.
  - err pulses in the cycle after accept.
  - FSM stays in IDLE; no state changes; no done.
- CONNECT, WRITE state (1 cycle):
  - Set presence of [a][b] and [b][a] to 1.
  - Set the age of both entries to 0. This applies even if the edge already existed.
  - Set node_valid for a and b.
- CONNECT, AGE state (NODE_COUNT cycles), index i = 0..NODE_COUNT-1:
  - If i != a, i != b and edge [a][i] is present, increment the age of [a][i] and [i][a] together.
  - The increment saturates at 2^AGE_W-1.
- PRUNE, PRUNE_EDGE state (NODE_COUNT*(NODE_COUNT-1)/2 cycles):
  - Walks pairs i<j in row-major order.
  - If the edge is present and age >= AGE_MAX, clear presence in both directions, reset age to 0, and increment pruned_count.
  - pruned_count is cleared on PRUNE accept.
- PRUNE, PRUNE_NODE state (NODE_COUNT cycles; GAM_NODE_PRUNE_EN only): node_valid[class][i] is cleared if row i of the class has no present edge.
- Other classes are never touched by a command.
- Query port:
  - q_present and q_age update every cycle from the q_* address, including while busy.
  - A read of an entry being written in the same cycle returns the old value.
  - A query with q_a == q_b returns 0.

## Timing
- Reset values:
  - cmd_ready = 1; done = 0; err = 0; pruned_count = 0.
  - All node_valid bits, presence bits and ages = 0; q_present = 0; q_age = 0.
- CONNECT accepted at cycle T: WRITE at T+1, AGE from T+2 to T+1+NODE_COUNT; done and cmd_ready high at T+2+NODE_COUNT.
- PRUNE accepted at T: done at T+1+P+N, where P = NODE_COUNT*(NODE_COUNT-1)/2 and N = NODE_COUNT (N = 0 without the macro).
- done coincides with the return to IDLE. A new command can be accepted in the done cycle.
- cmd_ready is low from the cycle after accept until the done cycle.
- Query latency is 1 cycle.
- rst_n asserted mid-operation immediately clears all state. No done pulse is issued for the aborted command.

## Configuration
- GAM_NODE_PRUNE_EN:
  - Defined: PRUNE runs PRUNE_NODE after PRUNE_EDGE and invalidates isolated nodes.
  - Undefined: PRUNE ends after PRUNE_EDGE, node_valid is only ever set by CONNECT, and the PRUNE_NODE logic is absent.

## Test plan
- Reset, then CONNECT c=1 a=2 b=5 -> done at T+18 (NODE_COUNT=16); query (1,2,5) and (1,5,2) -> present=1, age=0; node_valid bits 18 and 21 set.
- CONNECT (0,3,4), (0,3,7), (0,3,4) -> query (0,3,7) age=1 and (0,3,4) age=0; second CONNECT leaves (0,3,4) age=1 before the third resets it.
- CONNECT (0,0,1), then 50 CONNECTs (0,0,2), then PRUNE c=0 -> edge (0,1) cleared; pruned_count=1; node 1 invalid with the macro, still valid without it; done at T+1+120+16 with the macro.
- CONNECT a=b=6 -> err pulse 1 cycle after accept; cmd_ready stays 1; no done; memory unchanged.
- Age saturation (AGE_W=3) -> age holds at 7 after more than 7 aging events.
- rst_n low during AGE -> all outputs at reset values, cmd_ready=1 on release, no done pulse.

Source files
------------

// File: rtl/gam_connection_memory.sv
// rtl/gam_connection_memory.sv - per-class GAM edge memory with connect/age and prune sweeps
// Define GAM_NODE_PRUNE_EN to add the PRUNE_NODE pass that invalidates isolated nodes.
module gam_connection_memory #(
  parameter int CLASS_COUNT = 4,
  parameter int NODE_COUNT  = 16,
  parameter int AGE_W       = 6,
  parameter int AGE_MAX     = 50
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       cmd_valid,
  output logic                                       cmd_ready,
  input  logic                                       cmd_op,
  input  logic [$clog2(CLASS_COUNT)-1:0]             cmd_class,
  input  logic [$clog2(NODE_COUNT)-1:0]              cmd_node_a,
  input  logic [$clog2(NODE_COUNT)-1:0]              cmd_node_b,
  output logic                                       done,
  output logic                                       err,
  output logic [$clog2(NODE_COUNT*NODE_COUNT):0]     pruned_count,
  output logic [CLASS_COUNT*NODE_COUNT-1:0]          node_valid,
  input  logic [$clog2(CLASS_COUNT)-1:0]             q_class,
  input  logic [$clog2(NODE_COUNT)-1:0]              q_a,
  input  logic [$clog2(NODE_COUNT)-1:0]              q_b,
  output logic                                       q_present,
  output logic [AGE_W-1:0]                           q_age
);
  localparam int CW = $clog2(CLASS_COUNT);
  localparam int NW = $clog2(NODE_COUNT);
  localparam logic [AGE_W-1:0] AGE_SAT = '1;
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);
  localparam logic [NW-1:0]    IDX_LAST = NW'(NODE_COUNT - 1);
  localparam logic [NW-1:0]    IDX_PENULT = NW'(NODE_COUNT - 2);

  typedef enum logic [2:0] {IDLE, WRITE, AGE, PRUNE_EDGE, PRUNE_NODE} state_t;
  state_t state, state_nx;

  logic [NODE_COUNT-1:0] pres [CLASS_COUNT][NODE_COUNT];
  logic [AGE_W-1:0]      age  [CLASS_COUNT][NODE_COUNT][NODE_COUNT];
  logic [NODE_COUNT-1:0] nv   [CLASS_COUNT];
  logic [CW-1:0]         r_class;
  logic [NW-1:0]         r_a, r_b, idx_i, idx_j;
  logic [31:0]           cls_ext, a_ext, b_ext;
  logic                  cmd_bad, last_idx, last_pair;

  assign cls_ext   = 32'(cmd_class);
  assign a_ext     = 32'(cmd_node_a);
  assign b_ext     = 32'(cmd_node_b);
  assign cmd_bad   = (cls_ext >= 32'(CLASS_COUNT)) ||
                     (!cmd_op && ((cmd_node_a == cmd_node_b) ||
                                  (a_ext >= 32'(NODE_COUNT)) || (b_ext >= 32'(NODE_COUNT))));
  assign last_idx  = (idx_i == IDX_LAST);
  assign last_pair = (idx_i == IDX_PENULT) && (idx_j == IDX_LAST);
  assign cmd_ready = (state == IDLE);

  for (genvar c = 0; c < CLASS_COUNT; c++) begin : g_nv
    assign node_valid[c*NODE_COUNT +: NODE_COUNT] = nv[c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (cmd_valid && !cmd_bad) state_nx = cmd_op ? PRUNE_EDGE : WRITE;
      WRITE:      state_nx = AGE;
      AGE:        if (last_idx) state_nx = IDLE;
`ifdef GAM_NODE_PRUNE_EN
      PRUNE_EDGE: if (last_pair) state_nx = PRUNE_NODE;
      PRUNE_NODE: if (last_idx) state_nx = IDLE;
`else
      PRUNE_EDGE: if (last_pair) state_nx = IDLE;
`endif
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done         <= 1'b0;
      err          <= 1'b0;
      pruned_count <= '0;
      r_class      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      idx_i        <= '0;
      idx_j        <= '0;
      q_present    <= 1'b0;
      q_age        <= '0;
      for (int c = 0; c < CLASS_COUNT; c++) begin
        nv[c] <= '0;
        for (int i = 0; i < NODE_COUNT; i++) begin
          pres[c][i] <= '0;
          for (int j = 0; j < NODE_COUNT; j++) age[c][i][j] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      // Nonblocking read: a same-cycle write is seen on the following query.
      if (q_a != q_b) begin
        q_present <= pres[q_class][q_a][q_b];
        q_age     <= age[q_class][q_a][q_b];
      end else begin
        q_present <= 1'b0;
        q_age     <= '0;
      end
      case (state)
        IDLE: if (cmd_valid) begin
          if (cmd_bad) begin
            err <= 1'b1;
          end else begin
            r_class <= cmd_class;
            r_a     <= cmd_node_a;
            r_b     <= cmd_node_b;
            idx_i   <= '0;
            idx_j   <= NW'(1);
            if (cmd_op) pruned_count <= '0;
          end
        end
        WRITE: begin
          pres[r_class][r_a][r_b] <= 1'b1;
          pres[r_class][r_b][r_a] <= 1'b1;
          age[r_class][r_a][r_b]  <= '0;
          age[r_class][r_b][r_a]  <= '0;
          nv[r_class][r_a]        <= 1'b1;
          nv[r_class][r_b]        <= 1'b1;
          idx_i                   <= '0;
        end
        AGE: begin
          if (idx_i != r_a && idx_i != r_b && pres[r_class][r_a][idx_i] &&
              age[r_class][r_a][idx_i] != AGE_SAT) begin
            age[r_class][r_a][idx_i] <= age[r_class][r_a][idx_i] + 1'b1;
            age[r_class][idx_i][r_a] <= age[r_class][r_a][idx_i] + 1'b1;
          end
          idx_i <= idx_i + 1'b1;
          if (last_idx) done <= 1'b1;
        end
        PRUNE_EDGE: begin
          if (pres[r_class][idx_i][idx_j] && age[r_class][idx_i][idx_j] >= AGE_LIM) begin
            pres[r_class][idx_i][idx_j] <= 1'b0;
            pres[r_class][idx_j][idx_i] <= 1'b0;
            age[r_class][idx_i][idx_j]  <= '0;
            age[r_class][idx_j][idx_i]  <= '0;
            pruned_count                <= pruned_count + 1'b1;
          end
          if (last_pair) begin
            idx_i <= '0;
`ifndef GAM_NODE_PRUNE_EN
            done  <= 1'b1;
`endif
          end else if (idx_j == IDX_LAST) begin
            idx_i <= idx_i + 1'b1;
            idx_j <= idx_i + NW'(2);
          end else begin
            idx_j <= idx_j + 1'b1;
          end
        end
`ifdef GAM_NODE_PRUNE_EN
        PRUNE_NODE: begin
          if (~|pres[r_class][idx_i]) nv[r_class][idx_i] <= 1'b0;
          idx_i <= idx_i + 1'b1;
          if (last_idx) done <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gam_connection_memory.sv
// tb/tb_gam_connection_memory.sv - randomized bench against a command-level model of the edge memory
module tb_gam_connection_memory;
  localparam int CC = 4, NC = 16, AW = 6, AM = 50;
  localparam int P = NC * (NC - 1) / 2;
`ifdef GAM_NODE_PRUNE_EN
  localparam int NPASS = NC;
`else
  localparam int NPASS = 0;
`endif
  localparam int SAT = 2**AW - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_op = 1'b0, cmd_ready, done, err, q_present;
  logic [1:0] cmd_class = '0, q_class = '0;
  logic [3:0] cmd_node_a = '0, cmd_node_b = '0, q_a = '0, q_b = '0;
  logic [8:0] pruned_count;
  logic [63:0] node_valid;
  logic [AW-1:0] q_age;

  gam_connection_memory #(.CLASS_COUNT(CC), .NODE_COUNT(NC), .AGE_W(AW), .AGE_MAX(AM)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_class(cmd_class), .cmd_node_a(cmd_node_a), .cmd_node_b(cmd_node_b), .done(done),
    .err(err), .pruned_count(pruned_count), .node_valid(node_valid), .q_class(q_class),
    .q_a(q_a), .q_b(q_b), .q_present(q_present), .q_age(q_age));

  always #5 clk = ~clk;

  // Command-level model: each accepted command is applied atomically.
  bit pm [CC][NC][NC];
  int am [CC][NC][NC];
  bit [63:0] nvm;
  int pcm;
  int n_vec = 0, n_err = 0;
  int cyc = 0, acc_cyc = -100, lat = 0;
  bit rej = 1'b0, hold_q = 1'b0;
  int lqc = 0, lqa = 0, lqb = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < CC; c++)
      for (int i = 0; i < NC; i++)
        for (int j = 0; j < NC; j++) begin
          pm[c][i][j] = 1'b0;
          am[c][i][j] = 0;
        end
    nvm = '0;
    pcm = 0;
  endfunction

  function automatic void model_connect(input int c, input int a, input int b);
    pm[c][a][b] = 1'b1; pm[c][b][a] = 1'b1;
    am[c][a][b] = 0;    am[c][b][a] = 0;
    nvm[c*NC+a] = 1'b1; nvm[c*NC+b] = 1'b1;
    for (int i = 0; i < NC; i++)
      if (i != a && i != b && pm[c][a][i]) begin
        if (am[c][a][i] < SAT) am[c][a][i] = am[c][a][i] + 1;
        am[c][i][a] = am[c][a][i];
      end
  endfunction

  function automatic void model_prune(input int c);
    bit any;
    pcm = 0;
    for (int i = 0; i < NC; i++)
      for (int j = i + 1; j < NC; j++)
        if (pm[c][i][j] && am[c][i][j] >= AM) begin
          pm[c][i][j] = 1'b0; pm[c][j][i] = 1'b0;
          am[c][i][j] = 0;    am[c][j][i] = 0;
          pcm++;
        end
`ifdef GAM_NODE_PRUNE_EN
    for (int i = 0; i < NC; i++) begin
      any = 1'b0;
      for (int j = 0; j < NC; j++) any = any | pm[c][i][j];
      if (!any) nvm[c*NC+i] = 1'b0;
    end
`else
    any = 1'b0;
`endif
  endfunction

  // Per-cycle comparison of every output against the model and the command timeline.
  task automatic compare_cycle();
    bit busy, upd;
    busy = !rej && cyc > acc_cyc && cyc < acc_cyc + lat;
    upd  = !rej && cyc > acc_cyc && cyc <= acc_cyc + lat;
    check("cmd_ready", cmd_ready, !busy);
    check("done", done, !rej && cyc == acc_cyc + lat);
    check("err", err, rej && cyc == acc_cyc + 1);
    if (!busy) begin
      check("node_valid", node_valid, nvm);
      check("pruned_count", pruned_count, pcm);
    end
    if (!upd) begin
      check("q_present", q_present, (lqa == lqb) ? 0 : pm[lqc][lqa][lqb]);
      check("q_age", q_age, (lqa == lqb) ? 0 : am[lqc][lqa][lqb]);
    end
    if (!hold_q) begin
      q_class = 2'($urandom_range(0, 3));
      q_a     = 4'($urandom_range(0, 7));
      q_b     = 4'($urandom_range(0, 7));
    end
    lqc = int'(q_class); lqa = int'(q_a); lqb = int'(q_b);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_cmd(input bit op, input int c, input int a, input int b, input bit to_done);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_class  = 2'(c);
    cmd_node_a = 4'(a);
    cmd_node_b = 4'(b);
    tick();
    cmd_valid = 1'b0;
    acc_cyc   = cyc - 1;
    rej       = !op && a == b;
    lat       = op ? 1 + P + NPASS : NC + 2;
    if (!rej) begin
      if (op) model_prune(c);
      else    model_connect(c, a, b);
    end
    if (to_done)
      while (!rej && cyc < acc_cyc + lat) tick();
  endtask

  task automatic query(input int c, input int a, input int b);
    hold_q  = 1'b1;
    q_class = 2'(c); q_a = 4'(a); q_b = 4'(b);
    tick();
  endtask

  initial begin
    model_clear();
    repeat (3) tick();
    check("rst_ready", cmd_ready, 1);
    check("rst_node_valid", node_valid, 0);
    check("rst_pruned", pruned_count, 0);
    rst_n = 1'b1;
    tick();

    do_cmd(0, 1, 2, 5, 1);
    check("c125_done_at_T18", done, 1);
    query(1, 2, 5);
    check("q125_present", q_present, 1);
    check("q125_age", q_age, 0);
    query(1, 5, 2);
    check("q152_present", q_present, 1);
    check("nv_bit18", node_valid[18], 1);
    check("nv_bit21", node_valid[21], 1);

    do_cmd(0, 0, 3, 4, 1);
    do_cmd(0, 0, 3, 7, 1);
    query(0, 3, 4);
    check("q034_age_after_37", q_age, 1);
    do_cmd(0, 0, 3, 4, 1);
    query(0, 3, 7);
    check("q037_age", q_age, 1);
    query(0, 3, 4);
    check("q034_age_reset", q_age, 0);
    hold_q = 1'b0;

    do_cmd(0, 0, 0, 1, 1);
    repeat (50) do_cmd(0, 0, 0, 2, 1);
    query(0, 0, 1);
    check("q001_age50", q_age, 50);
    do_cmd(1, 0, 0, 0, 1);
    check("prune_done", done, 1);
    check("prune_count1", pruned_count, 1);
`ifdef GAM_NODE_PRUNE_EN
    check("node1_invalid", node_valid[1], 0);
`else
    check("node1_still_valid", node_valid[1], 1);
`endif
    query(0, 0, 1);
    check("q001_pruned", q_present, 0);
    do_cmd(0, 0, 0, 1, 1);
    repeat (48) do_cmd(0, 0, 0, 2, 1);
    do_cmd(0, 0, 0, 5, 1);
    query(0, 1, 0);
    check("q010_age49", q_age, 49);
    do_cmd(1, 0, 0, 0, 1);
    check("prune_count0", pruned_count, 0);
    query(0, 0, 1);
    check("q001_kept_at_49", q_present, 1);
    hold_q = 1'b0;

    do_cmd(0, 2, 6, 6, 1);
    check("self_edge_err", err, 1);
    check("self_edge_ready", cmd_ready, 1);
    check("self_edge_nv", node_valid[38], 0);
    tick();
    check("err_one_cycle", err, 0);

    do_cmd(0, 3, 0, 1, 1);
    repeat (70) do_cmd(0, 3, 0, 2, 1);
    query(3, 1, 0);
    check("age_saturated", q_age, SAT);
    hold_q = 1'b0;

    do_cmd(0, 1, 2, 9, 0);
    repeat (6) tick();
    rst_n   = 1'b0;
    acc_cyc = -100; lat = 0; rej = 1'b0;
    model_clear();
    tick();
    check("abort_ready", cmd_ready, 1);
    check("abort_done", done, 0);
    check("abort_nv", node_valid, 0);
    tick();
    rst_n = 1'b1;
    repeat (NC + 4) tick();

    for (int n = 0; n < 250; n++) begin
      int hi;
      hi = ($urandom_range(0, 4) == 0) ? 15 : 5;
      do_cmd($urandom_range(0, 9) == 0, $urandom_range(0, 3),
             $urandom_range(0, hi), $urandom_range(0, hi), 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
